conv_seq_ctrl: RTL and testbench

Parametrised sequencing core for the convolution accelerator. It loads a KSIZE×KSIZE weight set from the input SRAM, streams a runtime-programmable number of ifmap words into the conv datapath, and writes conv results to the output SRAM. It also packs results into GROUP-wide vectors for the batch-norm stage. It sits between the ICB slave's control registers and the input SRAM read port, conv_control, and the output SRAM write port. It supersedes the fixed 9-tap, fixed-480-word sequencer and adds runtime base/length, weight reuse, abort and partial-group flush.

---
 rtl/conv_seq_pkg.sv | 19 +
 rtl/conv_seq_ctrl_packer.sv | 90 +++++++++
 rtl/conv_seq_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution sequencer.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WLOAD  = 2'd1,
    S_STREAM = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Conventional location of the weight set in the input SRAM.
  localparam int unsigned WEIGHT_BASE = 4080;

  // Number of kernel taps for a square kernel of edge k.
  function automatic int unsigned taps(input int unsigned k);
    return k * k;
  endfunction

endpackage

// File: rtl/conv_seq_ctrl_packer.sv
// Output-SRAM address counter and GROUP-wide result packer for batch-norm.
module res_group_packer
  import conv_seq_pkg::*;
#(
  parameter int unsigned GROUP  = 4,
  parameter int unsigned RES_W  = 16,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [RES_W-1:0]         res_data,
  input  logic                     res_valid,
  input  logic                     flush,
  output logic                     out_wr_en,
  output logic [ADDR_W-1:0]        out_wr_addr,
  output logic [DATA_W-1:0]        out_wr_data,
  output logic [GROUP*RES_W-1:0]   grp_data,
  output logic [GROUP-1:0]         grp_keep,
  output logic                     grp_valid
);

  localparam int unsigned CW = $clog2(GROUP + 1);

  logic [ADDR_W-1:0]             wr_cnt_q, wr_cnt_d, addr_cur;
  logic [GROUP-1:0][RES_W-1:0]   slots_q, slots_d;
  logic [CW-1:0]                 fill_q, fill_d;
  logic [GROUP-1:0]              keep_d;
  logic [GROUP*RES_W-1:0]        data_d;
  logic                          emit;

  // Next counter/slot contents; a result arriving with flush is stored before the group is emitted.
  always_comb begin
    addr_cur = clr ? '0 : wr_cnt_q;
    wr_cnt_d = addr_cur + ADDR_W'(res_valid);
    slots_d  = slots_q;
    fill_d   = fill_q;
    if (res_valid) begin
      for (int unsigned i = 0; i < GROUP; i++) begin
        if (fill_q == CW'(i)) slots_d[i] = res_data;
      end
      fill_d = fill_q + CW'(1);
    end
    emit   = (fill_d == CW'(GROUP)) || (flush && (fill_d != '0));
    keep_d = '0;
    data_d = '0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      keep_d[i] = (CW'(i) < fill_d);
      if (keep_d[i]) data_d[i*RES_W +: RES_W] = slots_d[i];
    end
  end

  // Registered output-SRAM write and group outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      slots_q     <= '0;
      fill_q      <= '0;
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
      out_wr_data <= '0;
      grp_data    <= '0;
      grp_keep    <= '0;
      grp_valid   <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      out_wr_en <= res_valid;
      if (res_valid) begin
        out_wr_addr <= addr_cur;
        out_wr_data <= DATA_W'(res_data);
      end else if (clr) begin
        out_wr_addr <= '0;
      end
      grp_valid <= emit;
      if (emit) begin
        slots_q  <= '0;
        fill_q   <= '0;
        grp_data <= data_d;
        grp_keep <= keep_d;
      end else begin
        slots_q  <= slots_d;
        fill_q   <= fill_d;
        grp_data <= '0;
        grp_keep <= '0;
      end
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: weight load, ifmap streaming and result write-back.
module conv_seq_ctrl
  import conv_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned RES_W  = 16,
  parameter int unsigned GROUP  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          reuse_w,
  input  logic [ADDR_W-1:0]             weight_base,
  input  logic [ADDR_W-1:0]             ifmap_base,
  input  logic [ADDR_W-1:0]             ifmap_len,
  output logic                          rd_en,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [DATA_W-1:0]             rd_data,
  output logic [KSIZE*KSIZE*DATA_W-1:0] weights,
  output logic [DATA_W-1:0]             conv_num,
  output logic                          conv_num_valid,
  output logic                          busy,
  output logic                          done,
  input  logic [RES_W-1:0]              res_data,
  input  logic                          res_valid,
  input  logic                          flush,
  output logic                          out_wr_en,
  output logic [ADDR_W-1:0]             out_wr_addr,
  output logic [DATA_W-1:0]             out_wr_data,
  output logic [GROUP*RES_W-1:0]        grp_data,
  output logic [GROUP-1:0]              grp_keep,
  output logic                          grp_valid
);

  localparam int unsigned TAPS  = taps(KSIZE);
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t                     state_q, state_d;
  logic                       w_loaded_q, w_loaded_d;
  logic                       rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d;
  logic                       rd_pend_q, rd_pend_d;
  logic [TAPS-1:0][DATA_W-1:0] wt_q, wt_d;
  logic [CNT_W-1:0]           issue_q, issue_d, cap_q, cap_d;
  logic [ADDR_W-1:0]          wbase_q, wbase_d, ibase_q, ibase_d, len_q, len_d;
  logic                       done_q, done_d;
  logic                       pack_clr;

  // State register plus the registered read port, weight set and run parameters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      w_loaded_q <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_pend_q  <= 1'b0;
      wt_q       <= '0;
      issue_q    <= '0;
      cap_q      <= '0;
      wbase_q    <= '0;
      ibase_q    <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_loaded_q <= w_loaded_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_pend_q  <= rd_pend_d;
      wt_q       <= wt_d;
      issue_q    <= issue_d;
      cap_q      <= cap_d;
      wbase_q    <= wbase_d;
      ibase_q    <= ibase_d;
      len_q      <= len_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; reads are issued one cycle ahead so the first stream read
  // is launched on the same edge that captures the last weight word.
  always_comb begin
    state_d    = state_q;
    w_loaded_d = w_loaded_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_pend_d  = rd_en_q;
    wt_d       = wt_q;
    issue_d    = issue_q;
    cap_d      = cap_q;
    wbase_d    = wbase_q;
    ibase_d    = ibase_q;
    len_d      = len_q;
    done_d     = 1'b0;
    pack_clr   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pack_clr = 1'b1;
          wbase_d  = weight_base;
          ibase_d  = ifmap_base;
          len_d    = ifmap_len;
          issue_d  = CNT_W'(1);
          cap_d    = '0;
          if (reuse_w && w_loaded_q) begin
            state_d = S_STREAM;
            if (ifmap_len != '0) begin
              rd_en_d   = 1'b1;
              rd_addr_d = ifmap_base;
            end
          end else begin
            state_d    = S_WLOAD;
            w_loaded_d = 1'b0;
            rd_en_d    = 1'b1;
            rd_addr_d  = weight_base;
          end
        end
      end
      S_WLOAD: begin
        if (issue_q < CNT_W'(TAPS)) begin
          rd_en_d   = 1'b1;
          rd_addr_d = wbase_q + issue_q[ADDR_W-1:0];
          issue_d   = issue_q + CNT_W'(1);
        end
        if (rd_pend_q) begin
          for (int unsigned i = 0; i + 1 < TAPS; i++) wt_d[i] = wt_q[i+1];
          wt_d[TAPS-1] = rd_data;
          cap_d        = cap_q + CNT_W'(1);
          if (cap_q == CNT_W'(TAPS - 1)) begin
            state_d    = S_STREAM;
            w_loaded_d = 1'b1;
            issue_d    = CNT_W'(1);
            cap_d      = '0;
            if (len_q != '0) begin
              rd_en_d   = 1'b1;
              rd_addr_d = ibase_q;
            end
          end
        end
      end
      S_STREAM: begin
        if (len_q == '0) begin
          state_d = S_FINISH;
        end else begin
          if (issue_q < {1'b0, len_q}) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ibase_q + issue_q[ADDR_W-1:0];
            issue_d   = issue_q + CNT_W'(1);
          end
          if (rd_pend_q) begin
            cap_d = cap_q + CNT_W'(1);
            if (cap_q == {1'b0, len_q} - CNT_W'(1)) state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      rd_en_d   = 1'b0;
      rd_pend_d = 1'b0;
      done_d    = 1'b0;
      pack_clr  = 1'b0;
      if (state_q == S_WLOAD) w_loaded_d = 1'b0;
    end
  end

  assign rd_en          = rd_en_q;
  assign rd_addr        = rd_addr_q;
  assign weights        = wt_q;
  assign conv_num_valid = rd_pend_q && (state_q == S_STREAM);
  assign conv_num       = conv_num_valid ? rd_data : '0;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;

  res_group_packer #(
    .GROUP  (GROUP),
    .RES_W  (RES_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr         (pack_clr),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .flush       (flush),
    .out_wr_en   (out_wr_en),
    .out_wr_addr (out_wr_addr),
    .out_wr_data (out_wr_data),
    .grp_data    (grp_data),
    .grp_keep    (grp_keep),
    .grp_valid   (grp_valid)
  );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: sequencing timing, weight reuse, abort, packer and address wrap.
module tb_conv_seq_ctrl;
  import conv_seq_pkg::*;

  localparam int unsigned AW = 13, DW = 32, KS = 3, RW = 16, GP = 4, TP = KS * KS;

  logic              clk = 1'b0, rst = 1'b1;
  logic              start = 1'b0, abort = 1'b0, reuse_w = 1'b0;
  logic [AW-1:0]     weight_base = '0, ifmap_base = '0, ifmap_len = '0;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data = '0;
  logic [TP*DW-1:0]  weights;
  logic [DW-1:0]     conv_num;
  logic              conv_num_valid, busy, done;
  logic [RW-1:0]     res_data = '0;
  logic              res_valid = 1'b0, flush = 1'b0;
  logic              out_wr_en;
  logic [AW-1:0]     out_wr_addr;
  logic [DW-1:0]     out_wr_data;
  logic [GP*RW-1:0]  grp_data;
  logic [GP-1:0]     grp_keep;
  logic              grp_valid;

  int n_pass = 0, n_checks = 0;
  int r_first_rd, r_n_rd, r_n_wrd, r_rd_err, r_first_cv, r_n_cv, r_cv_err, r_gap, r_done, r_busy_ab, r_busy_end;

  conv_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW), .KSIZE(KS), .RES_W(RW), .GROUP(GP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .reuse_w(reuse_w),
    .weight_base(weight_base), .ifmap_base(ifmap_base), .ifmap_len(ifmap_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .weights(weights),
    .conv_num(conv_num), .conv_num_valid(conv_num_valid), .busy(busy), .done(done),
    .res_data(res_data), .res_valid(res_valid), .flush(flush),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
    .grp_data(grp_data), .grp_keep(grp_keep), .grp_valid(grp_valid)
  );

  always #5 clk = ~clk;

  // Input SRAM contents: word at WEIGHT_BASE+i is 0x1000+i (addresses wrap).
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] d;
    d = a - AW'(WEIGHT_BASE);
    return 32'h1000 + {19'b0, d};
  endfunction

  // One-cycle-latency SRAM read port.
  always @(posedge clk) if (rd_en) rd_data <= mem_word(rd_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Start a run (start in cycle 0) and observe cycles 1..maxc; run parameters are
  // scrambled after the start cycle to confirm they were sampled.
  task automatic do_run(input logic reuse, input logic [AW-1:0] len, input logic [AW-1:0] ibase,
                        input int n_w, input int abort_at, input int maxc);
    logic prev_cv;
    logic [AW-1:0] ea;
    r_first_rd = -1; r_n_rd = 0; r_n_wrd = 0; r_rd_err = 0; r_first_cv = -1;
    r_n_cv = 0; r_cv_err = 0; r_gap = 0; r_done = -1; r_busy_ab = -1;
    prev_cv = 1'b0;
    @(negedge clk);
    start = 1'b1; reuse_w = reuse; weight_base = AW'(WEIGHT_BASE);
    ifmap_base = ibase; ifmap_len = len;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; ifmap_len = 13'd5; ifmap_base = 13'd7777; weight_base = 13'd50;
      end
      if (rd_en) begin
        if (r_first_rd < 0) r_first_rd = k;
        if (r_n_rd < n_w) ea = AW'(WEIGHT_BASE) + AW'(r_n_rd);
        else              ea = ibase + AW'(r_n_rd - n_w);
        if (rd_addr !== ea) r_rd_err++;
        if (rd_addr >= 13'd4080 && rd_addr <= 13'd4088) r_n_wrd++;
        r_n_rd++;
      end
      if (conv_num_valid) begin
        if (r_n_cv > 0 && !prev_cv) r_gap++;
        if (r_first_cv < 0) r_first_cv = k;
        ea = ibase + AW'(r_n_cv);
        if (conv_num !== mem_word(ea)) r_cv_err++;
        r_n_cv++;
      end
      prev_cv = conv_num_valid;
      if (done) r_done = (r_done < 0) ? k : -2;
      if (k == abort_at + 1) begin
        r_busy_ab = int'(busy | rd_en | conv_num_valid);
        abort = 1'b0;
      end
      if (k == abort_at) abort = 1'b1;
    end
    r_busy_end = int'(busy);
  endtask

  task automatic send(input logic v, input logic [RW-1:0] d, input logic f);
    res_valid = v; res_data = d; flush = f;
    @(negedge clk);
    res_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cnv", {31'd0, conv_num_valid, conv_num}, 64'd0);
    check("rst_weights", 64'(weights == '0), 64'd1);
    check("rst_out_wr", {18'd0, out_wr_en, out_wr_addr, out_wr_data}, 64'd0);
    check("rst_grp", 64'({grp_valid, grp_keep} | 5'(grp_data != '0)), 64'd0);
    rst = 1'b0;

    // Fresh load, 8 ifmap words.
    do_run(1'b0, 13'd8, 13'd100, 9, -5, 26);
    check("r1_first_rd", 64'(r_first_rd), 64'd1);
    check("r1_n_rd", 64'(r_n_rd), 64'd17);
    check("r1_rd_addr_err", 64'(r_rd_err), 64'd0);
    check("r1_first_cv", 64'(r_first_cv), 64'd12);
    check("r1_n_cv", 64'(r_n_cv), 64'd8);
    check("r1_cv_data_err", 64'(r_cv_err), 64'd0);
    check("r1_cv_gap", 64'(r_gap), 64'd0);
    check("r1_done", 64'(r_done), 64'd21);
    check("r1_idle", 64'(r_busy_end), 64'd0);
    for (int t = 0; t < int'(TP); t++)
      check($sformatf("tap%0d", t), 64'(weights[t*DW +: DW]), 64'(32'h1000 + t));

    // Reuse held weights; observation window ends on done so the next start is back-to-back.
    do_run(1'b1, 13'd4, 13'd200, 0, -5, 7);
    check("r2_first_rd", 64'(r_first_rd), 64'd1);
    check("r2_weight_reads", 64'(r_n_wrd), 64'd0);
    check("r2_n_rd", 64'(r_n_rd), 64'd4);
    check("r2_first_cv", 64'(r_first_cv), 64'd2);
    check("r2_n_cv", 64'(r_n_cv), 64'd4);
    check("r2_cv_data_err", 64'(r_cv_err), 64'd0);
    check("r2_done", 64'(r_done), 64'd7);

    // Fresh load with empty ifmap, started the cycle after the previous done.
    do_run(1'b0, 13'd0, 13'd300, 9, -5, 16);
    check("r3_n_wrd", 64'(r_n_wrd), 64'd9);
    check("r3_n_rd", 64'(r_n_rd), 64'd9);
    check("r3_n_cv", 64'(r_n_cv), 64'd0);
    check("r3_done", 64'(r_done), 64'd13);

    // Abort in the 4th WLOAD cycle.
    do_run(1'b0, 13'd8, 13'd100, 9, 4, 25);
    check("r4_busy_after_abort", 64'(r_busy_ab), 64'd0);
    check("r4_n_rd", 64'(r_n_rd), 64'd4);
    check("r4_n_cv", 64'(r_n_cv), 64'd0);
    check("r4_no_done", 64'(r_done), 64'hFFFF_FFFF_FFFF_FFFF);

    // reuse_w after an aborted load must reload.
    do_run(1'b1, 13'd2, 13'd300, 9, -5, 20);
    check("r5_n_wrd", 64'(r_n_wrd), 64'd9);
    check("r5_first_cv", 64'(r_first_cv), 64'd12);
    check("r5_n_cv", 64'(r_n_cv), 64'd2);
    check("r5_done", 64'(r_done), 64'd15);

    // Packer and output write path (counter cleared by the last start).
    for (int i = 0; i < 6; i++) begin
      send(1'b1, RW'(16'h11 + i), 1'b0);
      check($sformatf("wr_en_%0d", i), 64'(out_wr_en), 64'd1);
      check($sformatf("wr_addr_%0d", i), 64'(out_wr_addr), 64'(i));
      check($sformatf("wr_data_%0d", i), 64'(out_wr_data), 64'(32'h11 + i));
      check($sformatf("grp_valid_%0d", i), 64'(grp_valid), (i == 3) ? 64'd1 : 64'd0);
      if (i == 3) begin
        check("grp1_keep", 64'(grp_keep), 64'hF);
        check("grp1_data", 64'(grp_data), 64'h0014_0013_0012_0011);
      end
    end
    send(1'b1, 16'h17, 1'b1);
    check("wr_addr_6", 64'(out_wr_addr), 64'd6);
    check("grp2_valid", 64'(grp_valid), 64'd1);
    check("grp2_keep", 64'(grp_keep), 64'h7);
    check("grp2_data", 64'(grp_data), 64'h0000_0017_0016_0015);
    send(1'b0, 16'h0, 1'b1);
    check("empty_flush", 64'(grp_valid), 64'd0);
    check("idle_wr_en", 64'(out_wr_en), 64'd0);

    // Address wrap over 8194 consecutive results.
    do_run(1'b1, 13'd0, 13'd0, 0, -5, 4);
    res_valid = 1'b1;
    for (int i = 0; i < 8194; i++) begin
      res_data = RW'(i);
      @(negedge clk);
      if (i == 8191) check("wrap_8191", 64'(out_wr_addr), 64'd8191);
      if (i == 8192) begin
        check("wrap_0", 64'(out_wr_addr), 64'd0);
        check("wrap_data", 64'(out_wr_data), 64'h2000);
      end
      if (i == 8193) check("wrap_1", 64'(out_wr_addr), 64'd1);
    end
    res_valid = 1'b0;
    do_run(1'b1, 13'd0, 13'd0, 0, -5, 4);
    send(1'b1, 16'h55, 1'b0);
    check("start_clears_addr", 64'(out_wr_addr), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
